// File: rtl/fly_wave_if.sv
// Handshake bundle between game control / fly datapath and the wave scheduler.
// master = game control and datapath side, slave = scheduler.
interface fly_wave_if #(
    parameter int FLY_COUNT = 4
);
    logic                 start;
    logic [FLY_COUNT-1:0] fly_alive;
    logic [FLY_COUNT-1:0] fly_hit;
    logic [FLY_COUNT-1:0] fly_escaped;
    logic                 spawn_valid;
    logic [2:0]           spawn_idx;
    logic [9:0]           spawn_x;
    logic [2:0]           speed_level;
    logic [3:0]           wave_num;
    logic [2:0]           lives;
    logic [15:0]          kill_count;
    logic                 wave_active;
    logic                 game_over;

    modport master (
        output start, fly_alive, fly_hit, fly_escaped,
        input  spawn_valid, spawn_idx, spawn_x, speed_level, wave_num,
               lives, kill_count, wave_active, game_over
    );

    modport slave (
        input  start, fly_alive, fly_hit, fly_escaped,
        output spawn_valid, spawn_idx, spawn_x, speed_level, wave_num,
               lives, kill_count, wave_active, game_over
    );
endinterface

// File: rtl/fly_wave_scheduler.sv
// Wave sequencer for the fly enemies: paced spawn commands, per-wave speed,
// kill/escape bookkeeping, lives and game-over control.
module fly_wave_scheduler #(
    parameter int FLY_COUNT = 4,
    parameter int TICK_DIV  = 250000,
    parameter int SPAWN_GAP = 20,
    parameter int INTER_GAP = 200,
    parameter int LIVES     = 3,
    parameter int BASE_X    = 100,
    parameter int SLOT_DX   = 40
) (
    input  logic     clk25,
    input  logic     rst_n,
    fly_wave_if.slave bus
);

    localparam int PRE_W   = $clog2(TICK_DIV + 1);
    localparam int GAP_MAX = (SPAWN_GAP > INTER_GAP) ? SPAWN_GAP : INTER_GAP;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0] SPAWN_RELOAD = GAP_W'(SPAWN_GAP - 1);
    localparam logic [GAP_W-1:0] INTER_RELOAD = GAP_W'(INTER_GAP - 1);
    localparam logic [2:0]       LAST_SLOT    = 3'(FLY_COUNT - 1);
    localparam logic [2:0]       LIVES_INIT   = 3'(LIVES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPAWN  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_INTER  = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    state_t             state_q,       state_d;
    logic [PRE_W-1:0]   presc_q,       presc_d;
    logic [GAP_W-1:0]   gap_q,         gap_d;
    logic [2:0]         ptr_q,         ptr_d;
    logic               spawn_valid_q, spawn_valid_d;
    logic [2:0]         spawn_idx_q,   spawn_idx_d;
    logic [9:0]         spawn_x_q,     spawn_x_d;
    logic [2:0]         speed_q,       speed_d;
    logic [3:0]         wave_q,        wave_d;
    logic [2:0]         lives_q,       lives_d;
    logic [15:0]        kill_q,        kill_d;
    logic               wave_active_q, wave_active_d;
    logic               game_over_q,   game_over_d;

    logic               tick_s;
    logic [3:0]         kills_s;
    logic [3:0]         escs_s;
    logic [16:0]        kill_sum_s;
    logic [15:0]        kill_sat_s;
    logic [2:0]         lives_dec_s;
    logic               lose_s;
    logic [9:0]         slot_x_s;

    function automatic logic [3:0] popcount(input logic [FLY_COUNT-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < FLY_COUNT; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Event arithmetic shared by SPAWN and ACTIVE; a hit masks an escape on the same slot.
    always_comb begin
        tick_s     = (presc_q == PRE_LAST);
        kills_s    = popcount(bus.fly_hit);
        escs_s     = popcount(bus.fly_escaped & ~bus.fly_hit);
        kill_sum_s = {1'b0, kill_q} + {13'd0, kills_s};
        kill_sat_s = kill_sum_s[16] ? 16'hFFFF : kill_sum_s[15:0];
        if (escs_s >= {1'b0, lives_q}) begin
            lives_dec_s = 3'd0;
        end else begin
            lives_dec_s = lives_q - escs_s[2:0];
        end
        lose_s   = (escs_s != 4'd0) && (lives_dec_s == 3'd0);
        slot_x_s = 10'(BASE_X) + 10'(ptr_q) * 10'(SLOT_DX)
                 + {4'd0, wave_q[1:0], 4'b0000};
    end

    // Next-state and next-output computation for the wave FSM.
    always_comb begin
        state_d       = state_q;
        presc_d       = tick_s ? {PRE_W{1'b0}} : presc_q + {{(PRE_W-1){1'b0}}, 1'b1};
        gap_d         = gap_q;
        ptr_d         = ptr_q;
        spawn_valid_d = 1'b0;
        spawn_idx_d   = spawn_idx_q;
        spawn_x_d     = spawn_x_q;
        speed_d       = speed_q;
        wave_d        = wave_q;
        lives_d       = lives_q;
        kill_d        = kill_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_d = ST_SPAWN;
                    wave_d  = 4'd0;
                    speed_d = 3'd0;
                    lives_d = LIVES_INIT;
                    kill_d  = 16'd0;
                    ptr_d   = 3'd0;
                    gap_d   = {GAP_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_SPAWN: begin
                kill_d  = kill_sat_s;
                lives_d = lives_dec_s;
                if (lose_s) begin
                    state_d = ST_OVER;
                end else if (tick_s && (gap_q == {GAP_W{1'b0}})) begin
                    spawn_valid_d = 1'b1;
                    spawn_idx_d   = ptr_q;
                    spawn_x_d     = slot_x_s;
                    gap_d         = SPAWN_RELOAD;
                    if (ptr_q == LAST_SLOT) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        ptr_d = ptr_q + 3'd1;
                    end
                end else if (tick_s) begin
                    gap_d = gap_q - {{(GAP_W-1){1'b0}}, 1'b1};
                end else begin
                    gap_d = gap_q;
                end
            end
            ST_ACTIVE: begin
                kill_d  = kill_sat_s;
                lives_d = lives_dec_s;
                // The spawn issued on the entry edge is still in flight until the datapath sees it.
                if (lose_s) begin
                    state_d = ST_OVER;
                end else if ((bus.fly_alive == {FLY_COUNT{1'b0}}) && !spawn_valid_q) begin
                    state_d = ST_INTER;
                    gap_d   = INTER_RELOAD;
                end else begin
                    state_d = state_q;
                end
            end
            ST_INTER: begin
                if (tick_s && (gap_q == {GAP_W{1'b0}})) begin
                    wave_d  = (wave_q == 4'd15) ? 4'd15 : wave_q + 4'd1;
                    speed_d = (wave_d > 4'd7) ? 3'd7 : wave_d[2:0];
                    ptr_d   = 3'd0;
                    gap_d   = {GAP_W{1'b0}};
                    state_d = ST_SPAWN;
                end else if (tick_s) begin
                    gap_d = gap_q - {{(GAP_W-1){1'b0}}, 1'b1};
                end else begin
                    gap_d = gap_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wave_active_d = (state_d == ST_SPAWN) || (state_d == ST_ACTIVE);
        game_over_d   = (state_d == ST_OVER);
    end

    // State and output registers.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            presc_q       <= {PRE_W{1'b0}};
            gap_q         <= {GAP_W{1'b0}};
            ptr_q         <= 3'd0;
            spawn_valid_q <= 1'b0;
            spawn_idx_q   <= 3'd0;
            spawn_x_q     <= 10'd0;
            speed_q       <= 3'd0;
            wave_q        <= 4'd0;
            lives_q       <= LIVES_INIT;
            kill_q        <= 16'd0;
            wave_active_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            gap_q         <= gap_d;
            ptr_q         <= ptr_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_idx_q   <= spawn_idx_d;
            spawn_x_q     <= spawn_x_d;
            speed_q       <= speed_d;
            wave_q        <= wave_d;
            lives_q       <= lives_d;
            kill_q        <= kill_d;
            wave_active_q <= wave_active_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.spawn_valid = spawn_valid_q;
    assign bus.spawn_idx   = spawn_idx_q;
    assign bus.spawn_x     = spawn_x_q;
    assign bus.speed_level = speed_q;
    assign bus.wave_num    = wave_q;
    assign bus.lives       = lives_q;
    assign bus.kill_count  = kill_q;
    assign bus.wave_active = wave_active_q;
    assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_fly_wave_scheduler.sv
// Directed bench for fly_wave_scheduler with a fast tick (TICK_DIV=4) and short gaps.
module tb_fly_wave_scheduler;

    localparam int FC = 4;

    logic clk25 = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fly_wave_if #(.FLY_COUNT(FC)) bus ();

    fly_wave_scheduler #(
        .FLY_COUNT (FC),
        .TICK_DIV  (4),
        .SPAWN_GAP (2),
        .INTER_GAP (3),
        .LIVES     (3),
        .BASE_X    (100),
        .SLOT_DX   (40)
    ) dut (
        .clk25 (clk25),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk25 = ~clk25;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    task automatic wait_spawn(input string tag, input int limit, output int dt,
                              output logic [2:0] idx, output logic [9:0] x);
        dt = 0;
        for (int c = 0; c < limit; c++) begin
            step();
            dt++;
            if (bus.spawn_valid) break;
        end
        check(tag, {31'd0, bus.spawn_valid}, 32'd1);
        idx = bus.spawn_idx;
        x   = bus.spawn_x;
    endtask

    initial begin
        int         dt;
        int         seen;
        int         ew;
        logic [2:0] idx;
        logic [9:0] x;

        bus.start       = 1'b0;
        bus.fly_alive   = 4'b0000;
        bus.fly_hit     = 4'b0000;
        bus.fly_escaped = 4'b0000;

        // Reset values
        #12;
        check("rst_spawn_valid", {31'd0, bus.spawn_valid}, 32'd0);
        check("rst_spawn_x",     {22'd0, bus.spawn_x},     32'd0);
        check("rst_lives",       {29'd0, bus.lives},       32'd3);
        check("rst_wave",        {28'd0, bus.wave_num},    32'd0);
        check("rst_kills",       {16'd0, bus.kill_count},  32'd0);
        check("rst_active",      {31'd0, bus.wave_active}, 32'd0);
        check("rst_over",        {31'd0, bus.game_over},   32'd0);
        #11;
        rst_n = 1'b1;
        step();

        // Wave 0: four spawns, 8 cycles apart
        bus.start     = 1'b1;
        bus.fly_alive = 4'b1111;
        step();
        bus.start = 1'b0;
        check("start_active", {31'd0, bus.wave_active}, 32'd1);
        for (int s = 0; s < 4; s++) begin
            wait_spawn("w0_spawn_seen", (s == 0) ? 10 : 20, dt, idx, x);
            check("w0_spawn_idx", {29'd0, idx}, s);
            check("w0_spawn_x",   {22'd0, x},   100 + s * 40);
            if (s > 0) check("w0_spawn_gap", dt, 32'd8);
        end
        step();
        check("w0_pulse_width", {31'd0, bus.spawn_valid}, 32'd0);
        check("w0_active",      {31'd0, bus.wave_active}, 32'd1);

        // Resolve the wave with kills
        bus.fly_hit = 4'b0011;
        step();
        bus.fly_hit   = 4'b1100;
        bus.fly_alive = 4'b1100;
        step();
        bus.fly_hit   = 4'b0000;
        bus.fly_alive = 4'b0000;
        step();
        check("w0_kills",      {16'd0, bus.kill_count},  32'd4);
        check("w0_inter_idle", {31'd0, bus.wave_active}, 32'd0);
        check("w0_inter_over", {31'd0, bus.game_over},   32'd0);

        wait_spawn("w1_spawn_seen", 40, dt, idx, x);
        check("w1_wave",  {28'd0, bus.wave_num},    32'd1);
        check("w1_speed", {29'd0, bus.speed_level}, 32'd1);
        check("w1_idx",   {29'd0, idx},             32'd0);
        check("w1_x",     {22'd0, x},               32'd116);

        // Three escapes end the game
        bus.fly_alive   = 4'b1111;
        bus.fly_escaped = 4'b0001;
        step();
        check("esc1_lives", {29'd0, bus.lives}, 32'd2);
        bus.fly_escaped = 4'b0010;
        step();
        check("esc2_lives", {29'd0, bus.lives}, 32'd1);
        check("esc2_over",  {31'd0, bus.game_over}, 32'd0);
        bus.fly_escaped = 4'b0100;
        step();
        bus.fly_escaped = 4'b0000;
        check("esc3_lives",  {29'd0, bus.lives},       32'd0);
        check("esc3_over",   {31'd0, bus.game_over},   32'd1);
        check("esc3_active", {31'd0, bus.wave_active}, 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.spawn_valid) seen++;
        end
        check("over_no_spawn", seen, 32'd0);
        check("over_held", {31'd0, bus.game_over}, 32'd1);

        // Restart from OVER
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("restart_lives", {29'd0, bus.lives},       32'd3);
        check("restart_wave",  {28'd0, bus.wave_num},    32'd0);
        check("restart_kills", {16'd0, bus.kill_count},  32'd0);
        check("restart_over",  {31'd0, bus.game_over},   32'd0);
        check("restart_act",   {31'd0, bus.wave_active}, 32'd1);

        // Hit and escape on the same slot counts as a kill only
        bus.fly_hit     = 4'b0001;
        bus.fly_escaped = 4'b0011;
        step();
        bus.fly_hit     = 4'b0000;
        bus.fly_escaped = 4'b0000;
        check("both_kills", {16'd0, bus.kill_count}, 32'd1);
        check("both_lives", {29'd0, bus.lives},      32'd2);

        // Asynchronous reset mid-SPAWN
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_lives",  {29'd0, bus.lives},       32'd3);
        check("arst_kills",  {16'd0, bus.kill_count},  32'd0);
        check("arst_active", {31'd0, bus.wave_active}, 32'd0);
        check("arst_valid",  {31'd0, bus.spawn_valid}, 32'd0);
        @(posedge clk25);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.spawn_valid) seen++;
        end
        check("arst_no_spawn", seen, 32'd0);
        check("arst_idle",     {31'd0, bus.wave_active}, 32'd0);

        // Kill counter saturation
        bus.start = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.fly_alive = 4'b1111;
        bus.fly_hit   = 4'b1111;
        repeat (16383) step();
        bus.fly_hit = 4'b0011;
        step();
        check("kill_fffe", {16'd0, bus.kill_count}, 32'h0000FFFE);
        bus.fly_hit = 4'b0111;
        step();
        check("kill_sat", {16'd0, bus.kill_count}, 32'h0000FFFF);
        bus.fly_hit = 4'b1111;
        step();
        bus.fly_hit = 4'b0000;
        check("kill_sat_hold", {16'd0, bus.kill_count}, 32'h0000FFFF);

        // Wave number and speed saturation over many intermissions
        bus.fly_alive = 4'b0000;
        for (int i = 1; i <= 18; i++) begin
            ew = (i > 15) ? 15 : i;
            wait_spawn("sat_spawn_seen", 60, dt, idx, x);
            check("sat_wave",  {28'd0, bus.wave_num},    ew);
            check("sat_speed", {29'd0, bus.speed_level}, (ew > 7) ? 7 : ew);
            check("sat_idx",   {29'd0, idx},             32'd0);
            check("sat_x",     {22'd0, x},               100 + (ew % 4) * 16);
            for (int s = 1; s < 4; s++) begin
                wait_spawn("sat_rest_seen", 20, dt, idx, x);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fly_wave_scheduler.md
Name: fly_wave_scheduler

Overview:
- Sequences the fly enemies in waves for the fly enemy datapath, which holds per-slot position, alive and hit state.
- Issues one-cycle spawn commands per slot, paced by a tick prescaler, and selects the descent speed level for each wave.
- Counts kills and escapes, tracks lives, and declares game over.
- Sits between top-level game control and the fly enemy datapath, on clk25.

Parameters:
- FLY_COUNT, 4, number of fly slots (1..8).
- TICK_DIV, 250000, clk25 cycles per scheduler tick (10 ms); a tick is a 1-cycle internal strobe.
- SPAWN_GAP, 20, ticks between consecutive spawns within a wave (>=1).
- INTER_GAP, 200, ticks of intermission between waves (>=1).
- LIVES, 3, starting lives (1..7).
- BASE_X, 100, x of slot 0 at spawn.
- SLOT_DX, 40, x spacing between slots.

Ports:
- clk25  in  1  25 MHz pixel clock, sole clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; sampled each cycle; begins a game from IDLE or OVER.
- fly_alive  in  FLY_COUNT  per-slot alive flags from the datapath.
- fly_hit  in  FLY_COUNT  per-slot 1-cycle kill pulses.
- fly_escaped  in  FLY_COUNT  per-slot 1-cycle pulses when a fly reaches the bottom.
- spawn_valid  out  1  1-cycle spawn command.
- spawn_idx  out  3  slot index for spawn_valid.
- spawn_x  out  10  spawn x for spawn_valid; spawn y is always 0.
- speed_level  out  3  descent speed selector for the datapath, min(wave_num,7).
- wave_num  out  4  current wave, 0-based.
- lives  out  3  remaining lives.
- kill_count  out  16  total kills, saturating.
- wave_active  out  1  high in SPAWN and ACTIVE.
- game_over  out  1  high in OVER.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; prescaler and gap counters=0.
  - spawn_valid=0, spawn_idx=0, spawn_x=0, speed_level=0, wave_num=0, lives=LIVES, kill_count=0, wave_active=0, game_over=0.
  - Reset mid-wave aborts immediately; no spawn pulse is emitted in the cycle of or after deassertion.
- Prescaler: counts 0..TICK_DIV-1 from reset; tick is asserted in the cycle the count wraps. It runs in all states.
- States:
  - IDLE: start=1 -> SPAWN. On entry to SPAWN from IDLE/OVER: wave_num=0, lives=LIVES, kill_count=0, slot pointer=0, gap counter=0.
  - SPAWN: on a tick with gap counter==0, emit spawn_valid=1 for exactly 1 cycle with:
    - spawn_idx = slot pointer
    - spawn_x = BASE_X + ptr*SLOT_DX + {wave_num[1:0],4'b0000}, truncated to 10 bits.
    - The gap counter then reloads to SPAWN_GAP-1 and decrements on each tick.
    - After slot FLY_COUNT-1 is spawned -> ACTIVE.
    - First spawn occurs on the first tick after entry.
  - ACTIVE: the wave is resolved when fly_alive==0 and no spawn is pending. Check this condition starting the cycle after entry.
    - Resolved -> INTERMISSION; load gap counter=INTER_GAP-1.
  - INTERMISSION: decrement the gap counter on each tick. On a tick with counter==0:
    - wave_num increments, saturating at 15.
    - Reset slot pointer and gap counter to 0.
    - -> SPAWN.
  - OVER: game_over=1; start=1 -> SPAWN as from IDLE.
  - start is ignored in SPAWN, ACTIVE and INTERMISSION.
- Event counting (in SPAWN and ACTIVE only; ignored elsewhere):
  - kill_count += popcount(fly_hit), saturating at 16'hFFFF.
  - Per escape pulse, lives decrements, saturating at 0.
  - Same slot with both hit and escape in one cycle counts as a kill only.
  - Multiple events in one cycle are all counted in that cycle.
- Game over: if lives would reach 0 -> OVER at the next edge, including from SPAWN with spawns pending; no further spawn_valid is issued.
- speed_level is registered and updates in the same cycle as wave_num.
- wave_active and game_over are decoded from registered state, with no combinational path from inputs.

Test Plan:
- TICK_DIV=4, SPAWN_GAP=2, FLY_COUNT=4, reset then start=1 for 1 cycle -> 4 spawn_valid pulses, idx 0..3, spawn_x 100,140,180,220, pulses 8 cycles apart (every 2nd tick); state ACTIVE after the 4th pulse.
- From ACTIVE, drive fly_alive 4'b1111->0 with fly_hit pulses 4'b0011 then 4'b1100 -> kill_count=4, INTERMISSION; after INTER_GAP ticks wave_num=1, speed_level=1, and the next spawn_x for slot 0 is 116.
- LIVES=3, three fly_escaped pulses in wave 0 -> lives 2,1,0; game_over=1 on the edge after the third; no further spawn_valid; start=1 -> lives=3, wave_num=0, kill_count=0.
- Same cycle fly_hit=4'b0001, fly_escaped=4'b0011 -> kill_count+1, lives-1 (slot 1 only).
- Assert rst_n=0 asynchronously mid-SPAWN (between clock edges) -> outputs reach reset values immediately; after release, no spawn_valid until start.
- Preload kill_count=16'hFFFE, fly_hit=4'b0111 -> kill_count=16'hFFFF; wave_num held at 15 across further intermissions, speed_level=7.
